// File: rtl/fft_pkg.sv
// fft_pkg -- shared constants and frame-state type for the FFT peak detector
// and the wider FFT integration.
//   FFT_DEPTH  : log2 of the frame length
//   SINK_WIDTH : width of the time-domain samples feeding the FFT core
//   FFT_WIDTH  : width of each FFT output component (bit growth of the core)
//   fft_frame_state_e : framing state machine encoding
package fft_pkg;

  localparam int FFT_DEPTH  = 11;
  localparam int SINK_WIDTH = 14;
  localparam int FFT_WIDTH  = SINK_WIDTH + (FFT_DEPTH + 1) / 2;

  typedef enum logic {
    IDLE     = 1'b0,
    IN_FRAME = 1'b1
  } fft_frame_state_e;

endpackage

// File: rtl/fft_mag_sq.sv
// fft_mag_sq -- registered exact squared magnitude Re*Re + Im*Im.
//   clk, aclr_n : clock, asynchronous active-low reset
//   en_i        : load enable (register holds when low)
//   re_i, im_i  : signed W-bit components
//   mag_o       : unsigned 2W-bit magnitude, one cycle after the enabled edge
module fft_mag_sq #(
  parameter int W = fft_pkg::FFT_WIDTH
) (
  input  logic                 clk,
  input  logic                 aclr_n,
  input  logic                 en_i,
  input  logic signed [W-1:0]  re_i,
  input  logic signed [W-1:0]  im_i,
  output logic [2*W-1:0]       mag_o
);

  logic signed [2*W-1:0] re_ext;
  logic signed [2*W-1:0] im_ext;
  logic signed [2*W-1:0] re_sq;
  logic signed [2*W-1:0] im_sq;
  logic [2*W-1:0]        mag_d;
  logic [2*W-1:0]        mag_q;

  // Widen before multiplying so the product is exact. Each square is at most
  // 2^(2W-2), so the sum (at most 2^(2W-1)) fits 2W bits unsigned.
  assign re_ext = {{W{re_i[W-1]}}, re_i};
  assign im_ext = {{W{im_i[W-1]}}, im_i};
  assign re_sq  = re_ext * re_ext;
  assign im_sq  = im_ext * im_ext;
  assign mag_d  = $unsigned(re_sq) + $unsigned(im_sq);

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      mag_q <= '0;
    end else if (en_i) begin
      mag_q <= mag_d;
    end
  end

  assign mag_o = mag_q;

endmodule

// File: rtl/fft_peak_detect.sv
// fft_peak_detect -- finds the strongest bin of each FFT output frame.
//   clk, aclr_n            : clock, asynchronous active-low reset
//   sink_sop/eop/valid     : frame framing, qualified by sink_valid, no backpressure
//   sink_Re, sink_Im       : signed bin components
//   peak_valid             : one-cycle pulse, result of a well-formed frame
//   peak_bin/mag/Re/Im     : strongest bin, held until the next result
//   error                  : one-cycle pulse on a framing violation
// Pipeline: framing/counter -> stage 1 (magnitude, bin, components, window flag)
// -> stage 2 (running maximum) -> output registers.
module fft_peak_detect #(
  parameter int FFT_DEPTH     = fft_pkg::FFT_DEPTH,
  parameter int FFT_WIDTH     = fft_pkg::FFT_WIDTH,
  parameter bit HALF_SPECTRUM = 1'b1,
  parameter bit SKIP_DC       = 1'b1
) (
  input  logic                         clk,
  input  logic                         aclr_n,
  input  logic                         sink_sop,
  input  logic                         sink_eop,
  input  logic                         sink_valid,
  input  logic signed [FFT_WIDTH-1:0]  sink_Re,
  input  logic signed [FFT_WIDTH-1:0]  sink_Im,
  output logic                         peak_valid,
  output logic [FFT_DEPTH-1:0]         peak_bin,
  output logic [2*FFT_WIDTH-1:0]       peak_mag,
  output logic signed [FFT_WIDTH-1:0]  peak_Re,
  output logic signed [FFT_WIDTH-1:0]  peak_Im,
  output logic                         error
);

  import fft_pkg::*;

  localparam int MW = 2 * FFT_WIDTH;
  localparam logic [FFT_DEPTH-1:0] LAST_BIN = '1;
  localparam logic [FFT_DEPTH-1:0] BIN_ONE  = {{(FFT_DEPTH-1){1'b0}}, 1'b1};

  // Framing
  fft_frame_state_e      state_q, state_d;
  logic [FFT_DEPTH-1:0]  cnt_q, cnt_d;
  logic [FFT_DEPTH-1:0]  beat_bin;
  logic                  beat_take;
  logic                  beat_done;
  logic                  beat_win;
  logic                  err_d;

  // Stage 1
  logic                  s1_valid_q, s1_sop_q, s1_win_q, s1_done_q;
  logic [FFT_DEPTH-1:0]  s1_bin_q;
  logic signed [FFT_WIDTH-1:0] s1_re_q, s1_im_q;
  logic [MW-1:0]         s1_mag;

  // Stage 2 (running maximum)
  logic                  have_q, have_d, fresh, take_max, s2_done_q;
  logic [MW-1:0]         max_mag_q;
  logic [FFT_DEPTH-1:0]  max_bin_q;
  logic signed [FFT_WIDTH-1:0] max_re_q, max_im_q;

  // Outputs
  logic                  peak_valid_q, error_q;
  logic [FFT_DEPTH-1:0]  peak_bin_q;
  logic [MW-1:0]         peak_mag_q;
  logic signed [FFT_WIDTH-1:0] peak_re_q, peak_im_q;

  // A sop beat always restarts at bin 0, whatever the counter says.
  assign beat_bin = sink_sop ? '0 : cnt_q;
  assign beat_win = (!SKIP_DC || (beat_bin != '0)) &&
                    (!HALF_SPECTRUM || !beat_bin[FFT_DEPTH-1]);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_d     = 1'b0;
    beat_take = 1'b0;
    beat_done = 1'b0;
    if (sink_valid) begin
      if (sink_sop && sink_eop) begin
        err_d   = 1'b1;
        state_d = IDLE;
        cnt_d   = '0;
      end else if (sink_sop) begin
        // sop while already in a frame discards the partial frame.
        beat_take = 1'b1;
        err_d     = (state_q == IN_FRAME);
        state_d   = IN_FRAME;
        cnt_d     = BIN_ONE;
      end else if (state_q == IN_FRAME) begin
        beat_take = 1'b1;
        if (cnt_q == LAST_BIN) begin
          // Last bin: either a clean end or a missing eop; never wrap.
          state_d   = IDLE;
          cnt_d     = '0;
          beat_done = sink_eop;
          err_d     = !sink_eop;
        end else if (sink_eop) begin
          err_d   = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + BIN_ONE;
        end
      end else if (sink_eop) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  fft_mag_sq #(
    .W (FFT_WIDTH)
  ) u_mag_sq (
    .clk    (clk),
    .aclr_n (aclr_n),
    .en_i   (beat_take),
    .re_i   (sink_Re),
    .im_i   (sink_Im),
    .mag_o  (s1_mag)
  );

  // Stage 1: flags pulse per accepted beat, data registers hold otherwise.
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      s1_valid_q <= 1'b0;
      s1_sop_q   <= 1'b0;
      s1_win_q   <= 1'b0;
      s1_done_q  <= 1'b0;
      s1_bin_q   <= '0;
      s1_re_q    <= '0;
      s1_im_q    <= '0;
    end else begin
      s1_valid_q <= beat_take;
      s1_sop_q   <= beat_take && sink_sop;
      s1_done_q  <= beat_done;
      if (beat_take) begin
        s1_win_q <= beat_win;
        s1_bin_q <= beat_bin;
        s1_re_q  <= sink_Re;
        s1_im_q  <= sink_Im;
      end
    end
  end

  // Stage 2: a frame start forgets the previous maximum, so the first
  // in-window bin loads unconditionally; afterwards strictly greater wins,
  // which keeps the lowest bin on ties.
  assign fresh    = s1_sop_q ? 1'b0 : have_q;
  assign take_max = s1_valid_q && s1_win_q && (!fresh || (s1_mag > max_mag_q));
  assign have_d   = s1_valid_q ? (take_max || fresh) : have_q;

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      have_q    <= 1'b0;
      s2_done_q <= 1'b0;
      max_mag_q <= '0;
      max_bin_q <= '0;
      max_re_q  <= '0;
      max_im_q  <= '0;
    end else begin
      have_q    <= have_d;
      s2_done_q <= s1_done_q;
      if (take_max) begin
        max_mag_q <= s1_mag;
        max_bin_q <= s1_bin_q;
        max_re_q  <= s1_re_q;
        max_im_q  <= s1_im_q;
      end
    end
  end

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      peak_valid_q <= 1'b0;
      error_q      <= 1'b0;
      peak_bin_q   <= '0;
      peak_mag_q   <= '0;
      peak_re_q    <= '0;
      peak_im_q    <= '0;
    end else begin
      peak_valid_q <= s2_done_q;
      error_q      <= err_d;
      if (s2_done_q) begin
        peak_bin_q <= max_bin_q;
        peak_mag_q <= max_mag_q;
        peak_re_q  <= max_re_q;
        peak_im_q  <= max_im_q;
      end
    end
  end

  assign peak_valid = peak_valid_q;
  assign peak_bin   = peak_bin_q;
  assign peak_mag   = peak_mag_q;
  assign peak_Re    = peak_re_q;
  assign peak_Im    = peak_im_q;
  assign error      = error_q;

endmodule

// File: tb/tb_fft_peak_detect.sv
// tb_fft_peak_detect -- randomized self-checking bench for fft_peak_detect.
// Two instances share the stimulus: dut_a searches the half spectrum without
// DC, dut_b searches the whole spectrum including DC.
module tb_fft_peak_detect;

  localparam int D = 11;
  localparam int W = 20;
  localparam int N = 2048;

  logic clk = 1'b0;
  logic aclr_n = 1'b0;
  logic sink_sop = 1'b0;
  logic sink_eop = 1'b0;
  logic sink_valid = 1'b0;
  logic signed [W-1:0] sink_Re = '0;
  logic signed [W-1:0] sink_Im = '0;

  logic pv_a, err_a, pv_b, err_b;
  logic [D-1:0] bin_a, bin_b;
  logic [2*W-1:0] mag_a, mag_b;
  logic signed [W-1:0] re_a, im_a, re_b, im_b;

  always #5 clk = ~clk;

  fft_peak_detect #(.FFT_DEPTH(D), .FFT_WIDTH(W), .HALF_SPECTRUM(1'b1), .SKIP_DC(1'b1)) dut_a (
    .clk(clk), .aclr_n(aclr_n), .sink_sop(sink_sop), .sink_eop(sink_eop),
    .sink_valid(sink_valid), .sink_Re(sink_Re), .sink_Im(sink_Im),
    .peak_valid(pv_a), .peak_bin(bin_a), .peak_mag(mag_a),
    .peak_Re(re_a), .peak_Im(im_a), .error(err_a)
  );

  fft_peak_detect #(.FFT_DEPTH(D), .FFT_WIDTH(W), .HALF_SPECTRUM(1'b0), .SKIP_DC(1'b0)) dut_b (
    .clk(clk), .aclr_n(aclr_n), .sink_sop(sink_sop), .sink_eop(sink_eop),
    .sink_valid(sink_valid), .sink_Re(sink_Re), .sink_Im(sink_Im),
    .peak_valid(pv_b), .peak_bin(bin_b), .peak_mag(mag_b),
    .peak_Re(re_b), .peak_Im(im_b), .error(err_b)
  );

  int fre[N];
  int fim[N];
  int n_checks = 0;
  int n_errors = 0;
  int pv_cnt_a = 0, err_cnt_a = 0, pv_cnt_b = 0, err_cnt_b = 0;

  // Pulse counters: values registered at one edge are seen at the next.
  always @(posedge clk) begin
    if (aclr_n) begin
      if (pv_a)  pv_cnt_a++;
      if (err_a) err_cnt_a++;
      if (pv_b)  pv_cnt_b++;
      if (err_b) err_cnt_b++;
    end
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: strongest bin under the search window, lowest index on ties.
  function automatic void ref_peak(input bit half, input bit skip,
                                   output int bin, output longint mag);
    int lim;
    bit found;
    longint m;
    lim = half ? N / 2 : N;
    found = 1'b0;
    bin = 0;
    mag = 0;
    for (int b = (skip ? 1 : 0); b < lim; b++) begin
      m = longint'(fre[b]) * fre[b] + longint'(fim[b]) * fim[b];
      if (!found || m > mag) begin
        found = 1'b1;
        mag = m;
        bin = b;
      end
    end
  endfunction

  task automatic clear_frame();
    for (int b = 0; b < N; b++) begin
      fre[b] = 0;
      fim[b] = 0;
    end
  endtask

  task automatic rand_frame(input int amp);
    for (int b = 0; b < N; b++) begin
      fre[b] = int'($urandom_range(0, 2 * amp)) - amp;
      fim[b] = int'($urandom_range(0, 2 * amp)) - amp;
    end
  endtask

  // Two equal-magnitude bins with different components: lowest must win.
  task automatic inject_tie();
    int a, c;
    a = int'($urandom_range(1, 400));
    c = int'($urandom_range(a + 1, 1000));
    fre[a] = 30000;  fim[a] = -40000;
    fre[c] = -40000; fim[c] = 30000;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    sink_valid = 1'b0;
    sink_sop   = 1'($urandom_range(0, 1));
    sink_eop   = 1'($urandom_range(0, 1));
    sink_Re    = W'($urandom);
    sink_Im    = W'($urandom);
  endtask

  task automatic send_beat(input bit sop, input bit eop, input int re, input int im);
    @(negedge clk);
    sink_valid = 1'b1;
    sink_sop   = sop;
    sink_eop   = eop;
    sink_Re    = re[W-1:0];
    sink_Im    = im[W-1:0];
  endtask

  task automatic send_frame(input int first, input int last, input bit with_sop,
                            input bit with_eop, input int gap_pct);
    int g;
    for (int b = first; b <= last; b++) begin
      g = (int'($urandom_range(0, 99)) < gap_pct) ? int'($urandom_range(1, 3)) : 0;
      repeat (g) idle_cycle();
      send_beat(with_sop && (b == first), with_eop && (b == last), fre[b], fim[b]);
    end
  endtask

  // Called right after the eop beat has been driven.
  task automatic expect_peak(input string tag);
    int eb_a, eb_b;
    longint em_a, em_b;
    ref_peak(1'b1, 1'b1, eb_a, em_a);
    ref_peak(1'b0, 1'b0, eb_b, em_b);
    idle_cycle();
    chk({tag, ".err"}, longint'(err_a), 0);
    chk({tag, ".pv_early1"}, longint'(pv_a), 0);
    idle_cycle();
    chk({tag, ".pv_early2"}, longint'(pv_a), 0);
    idle_cycle();
    chk({tag, ".pv"}, longint'(pv_a), 1);
    chk({tag, ".bin"}, longint'(bin_a), eb_a);
    chk({tag, ".mag"}, longint'(mag_a), em_a);
    chk({tag, ".re"}, longint'(re_a), fre[eb_a]);
    chk({tag, ".im"}, longint'(im_a), fim[eb_a]);
    chk({tag, ".full_pv"}, longint'(pv_b), 1);
    chk({tag, ".full_bin"}, longint'(bin_b), eb_b);
    chk({tag, ".full_mag"}, longint'(mag_b), em_b);
    idle_cycle();
    chk({tag, ".pv_pulse"}, longint'(pv_a), 0);
    chk({tag, ".bin_held"}, longint'(bin_a), eb_a);
    $display("frame %s: peak_bin=%0d peak_mag=%0d full_bin=%0d full_mag=%0d",
             tag, bin_a, mag_a, bin_b, mag_b);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".pv"}, longint'(pv_a), 0);
    chk({tag, ".err"}, longint'(err_a), 0);
    chk({tag, ".bin"}, longint'(bin_a), 0);
    chk({tag, ".mag"}, longint'(mag_a), 0);
    chk({tag, ".re"}, longint'(re_a), 0);
    chk({tag, ".im"}, longint'(im_a), 0);
    chk({tag, ".full_mag"}, longint'(mag_b), 0);
  endtask

  initial begin
    int e0, p0;
    aclr_n = 1'b0;
    repeat (3) idle_cycle();
    chk_reset_outputs("reset");
    @(negedge clk);
    aclr_n = 1'b1;
    idle_cycle();

    // Single tone
    clear_frame();
    fre[100] = 300;
    fim[100] = -400;
    send_frame(0, N - 1, 1'b1, 1'b1, 0);
    expect_peak("tone");
    chk("tone.bin_const", longint'(bin_a), 100);
    chk("tone.mag_const", longint'(mag_a), 250000);
    chk("tone.re_const", longint'(re_a), 300);
    chk("tone.im_const", longint'(im_a), -400);

    // Ties and the upper half
    clear_frame();
    fre[5] = 1000;
    fre[9] = 1000;
    fre[2000] = 9000;
    send_frame(0, N - 1, 1'b1, 1'b1, 5);
    expect_peak("tie");
    chk("tie.bin_const", longint'(bin_a), 5);
    chk("tie.mag_const", longint'(mag_a), 1000000);
    chk("tie.full_bin_const", longint'(bin_b), 2000);

    // DC exclusion
    clear_frame();
    fre[0] = 50000;
    fre[7] = 10;
    fim[7] = 10;
    send_frame(0, N - 1, 1'b1, 1'b1, 5);
    expect_peak("dc");
    chk("dc.bin_const", longint'(bin_a), 7);
    chk("dc.mag_const", longint'(mag_a), 200);
    chk("dc.full_bin_const", longint'(bin_b), 0);

    // Most negative components
    clear_frame();
    fre[3] = -524288;
    fim[3] = -524288;
    send_frame(0, N - 1, 1'b1, 1'b1, 10);
    expect_peak("minval");
    chk("minval.mag_const", longint'(mag_a), 64'd549755813888);

    // sop reasserted at bin 500
    e0 = err_cnt_a;
    p0 = pv_cnt_a;
    rand_frame(5000);
    send_frame(0, 499, 1'b1, 1'b0, 10);
    rand_frame(20000);
    inject_tie();
    send_frame(0, N - 1, 1'b1, 1'b1, 20);
    expect_peak("resop");
    chk("resop.err_count", longint'(err_cnt_a - e0), 1);
    chk("resop.pv_count", longint'(pv_cnt_a - p0), 1);

    // Early eop, then reset mid-frame
    e0 = err_cnt_a;
    p0 = pv_cnt_a;
    rand_frame(3000);
    send_frame(0, 1000, 1'b1, 1'b1, 5);
    idle_cycle();
    chk("early_eop.err_pulse", longint'(err_a), 1);
    idle_cycle();
    chk("early_eop.err_clear", longint'(err_a), 0);
    repeat (3) idle_cycle();
    chk("early_eop.no_pv", longint'(pv_cnt_a - p0), 0);
    chk("early_eop.full_no_pv", longint'(pv_cnt_b), longint'(pv_cnt_a));
    rand_frame(3000);
    send_frame(0, 699, 1'b1, 1'b0, 5);
    @(negedge clk);
    sink_valid = 1'b0;
    aclr_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    repeat (2) idle_cycle();
    chk_reset_outputs("midreset_hold");
    @(negedge clk);
    aclr_n = 1'b1;
    send_frame(700, N - 2, 1'b0, 1'b0, 0);
    repeat (3) idle_cycle();
    chk("midreset.no_pv", longint'(pv_cnt_a - p0), 0);
    rand_frame(8000);
    inject_tie();
    send_frame(0, N - 1, 1'b1, 1'b1, 10);
    expect_peak("after_reset");
    chk("after_reset.err_count", longint'(err_cnt_a - e0), 1);
    chk("after_reset.pv_count", longint'(pv_cnt_a - p0), 1);

    // Missing eop on the last bin, and sop+eop on one beat
    e0 = err_cnt_a;
    p0 = pv_cnt_a;
    rand_frame(1000);
    send_frame(0, N - 1, 1'b1, 1'b0, 0);
    idle_cycle();
    chk("no_eop.err_pulse", longint'(err_a), 1);
    send_beat(1'b1, 1'b1, 5, 5);
    idle_cycle();
    chk("sop_eop.err_pulse", longint'(err_a), 1);
    repeat (4) idle_cycle();
    chk("framing.err_count", longint'(err_cnt_a - e0), 2);
    chk("framing.pv_count", longint'(pv_cnt_a - p0), 0);

    // Random frames
    for (int f = 0; f < 3; f++) begin
      e0 = err_cnt_a;
      rand_frame(int'($urandom_range(100, 20000)));
      if (f != 1) inject_tie();
      send_frame(0, N - 1, 1'b1, 1'b1, int'($urandom_range(0, 25)));
      expect_peak($sformatf("rand%0d", f));
      chk($sformatf("rand%0d.no_err", f), longint'(err_cnt_a - e0), 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
